// File: rtl/frame_max_if.sv
// Sample-in / result-out handshake bundle for frame_max_finder.
// The slave modport is the finder's side; master is the producer/consumer side.
interface frame_max_if #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 4,
    parameter int IDX_W     = $clog2(FRAME_LEN)
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_max;
    logic [IDX_W-1:0]  out_idx;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_max, out_idx
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_max, out_idx
    );
endinterface

// File: rtl/frame_max_finder.sv
// Per-frame peak finder: groups FRAME_LEN unsigned samples and reports the
// largest one and its 0-based position, holding the result until released.
//
// state | meaning
// IDLE  | no sample of the current frame accepted yet
// ACCUM | 1 .. FRAME_LEN-1 samples of the frame accepted
// HOLD  | result presented, waiting for out_ready
module frame_max_finder #(
    parameter int DATA_W    = 8,
    parameter int FRAME_LEN = 4,
    parameter int IDX_W     = $clog2(FRAME_LEN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    frame_max_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    state_t            state;
    logic [IDX_W-1:0]  count;
    logic [DATA_W-1:0] max_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              out_valid_reg;
    logic              accept;
    logic              release_res;

    assign bus.in_ready  = (state != HOLD) && !clear;
    assign accept        = bus.in_valid && bus.in_ready;
    assign release_res   = out_valid_reg && bus.out_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_max   = max_reg;
    assign bus.out_idx   = idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            max_reg       <= '0;
            idx_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else if (clear) begin
            // result registers are left alone; out_valid=0 marks them stale
            state         <= IDLE;
            count         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        max_reg <= bus.in_data;
                        idx_reg <= '0;
                        count   <= IDX_W'(1);
                        state   <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        // strict compare keeps the earliest index on ties
                        if (bus.in_data > max_reg) begin
                            max_reg <= bus.in_data;
                            idx_reg <= count;
                        end
                        if (count == LAST_IDX) begin
                            state         <= HOLD;
                            out_valid_reg <= 1'b1;
                        end else begin
                            count <= count + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (release_res) begin
                        out_valid_reg <= 1'b0;
                        count         <= '0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state         <= IDLE;
                    count         <= '0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_max_finder.sv
// Directed bench for frame_max_finder with FRAME_LEN=4, DATA_W=8.
module tb_frame_max_finder;
    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    int   n_checks = 0;
    int   n_fail   = 0;

    frame_max_if #(.DATA_W(8), .FRAME_LEN(4)) bus ();

    frame_max_finder #(.DATA_W(8), .FRAME_LEN(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // offers one sample for exactly one edge; returns at edge+1
    task automatic push(input logic [7:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
        push(a);
        push(b);
        push(c);
        push(d);
    endtask

    // called right after the edge that accepted the last sample, out_ready=1
    task automatic expect_pulse(input string tag, input logic [7:0] mx, input logic [1:0] ix);
        check_val({tag, "_valid"},   32'(bus.out_valid), 32'd1);
        check_val({tag, "_max"},     32'(bus.out_max),   32'(mx));
        check_val({tag, "_idx"},     32'(bus.out_idx),   32'(ix));
        check_val({tag, "_rdy_lo"},  32'(bus.in_ready),  32'd0);
        @(posedge clk);
        #1;
        check_val({tag, "_released"}, 32'(bus.out_valid), 32'd0);
        check_val({tag, "_rdy_hi"},   32'(bus.in_ready),  32'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #12;
        check_val("rst_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst_max",   32'(bus.out_max),   32'd0);
        check_val("rst_idx",   32'(bus.out_idx),   32'd0);
        check_val("rst_ready", 32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // out_ready high while idle must be ignored
        check_val("idle_valid", 32'(bus.out_valid), 32'd0);

        push4(8'd3, 8'd9, 8'd5, 8'd1);
        expect_pulse("basic", 8'd9, 2'd1);

        push4(8'd7, 8'd255, 8'd255, 8'd0);
        expect_pulse("tie", 8'd255, 2'd1);

        push4(8'd0, 8'd0, 8'd0, 8'd0);
        expect_pulse("zeros", 8'd0, 2'd0);

        // backpressure
        bus.out_ready = 1'b0;
        push4(8'd2, 8'd4, 8'd6, 8'd8);
        for (int i = 0; i < 5; i++) begin
            check_val($sformatf("bp_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            check_val($sformatf("bp_rdy_%0d", i),   32'(bus.in_ready),  32'd0);
            check_val($sformatf("bp_max_%0d", i),   32'(bus.out_max),   32'd8);
            check_val($sformatf("bp_idx_%0d", i),   32'(bus.out_idx),   32'd3);
            if (i == 2) begin
                // offered sample during HOLD must not be taken
                bus.in_valid = 1'b1;
                bus.in_data  = 8'd77;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("bp_released", 32'(bus.out_valid), 32'd0);
        check_val("bp_rdy_after", 32'(bus.in_ready), 32'd1);

        // gapped input
        push(8'd10);
        repeat (3) @(posedge clk);
        #1;
        check_val("gap_valid", 32'(bus.out_valid), 32'd0);
        check_val("gap_max",   32'(bus.out_max),   32'd10);
        push(8'd20);
        repeat (2) @(posedge clk);
        #1;
        push(8'd15);
        check_val("gap_valid2", 32'(bus.out_valid), 32'd0);
        push(8'd30);
        expect_pulse("gapped", 8'd30, 2'd3);

        // clear flushes partial frame and blocks a same-cycle sample
        push(8'd50);
        push(8'd60);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd99;
        #1;
        check_val("clr_rdy", 32'(bus.in_ready), 32'd0);
        @(posedge clk);
        #1;
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check_val("clr_valid", 32'(bus.out_valid), 32'd0);
        push4(8'd1, 8'd2, 8'd3, 8'd4);
        expect_pulse("clear", 8'd4, 2'd3);

        // async reset while holding a result
        bus.out_ready = 1'b0;
        push4(8'd10, 8'd200, 8'd20, 8'd30);
        check_val("hold_max", 32'(bus.out_max), 32'd200);
        check_val("hold_idx", 32'(bus.out_idx), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_valid", 32'(bus.out_valid), 32'd0);
        check_val("arst_max",   32'(bus.out_max),   32'd0);
        check_val("arst_idx",   32'(bus.out_idx),   32'd0);
        check_val("arst_rdy",   32'(bus.in_ready),  32'd1);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        push4(8'd5, 8'd1, 8'd1, 8'd1);
        expect_pulse("post_rst", 8'd5, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_max_finder.md
Name: frame_max_finder

Overview:
- Streaming companion to the registered minimum selector.
- Accepts a stream of unsigned samples over a valid/ready handshake and groups them into frames of FRAME_LEN samples.
- For each frame it returns the largest sample and its position inside the frame, on a second valid/ready handshake.
- Sits downstream of sample producers; it feeds control logic that needs a per-frame peak.

Parameters:
- DATA_W, 8: sample width in bits; samples are unsigned.
- FRAME_LEN, 4: samples per frame; must be at least 2.
- IDX_W, $clog2(FRAME_LEN): width of the index output.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous frame flush; active high.
- in_valid  input  1  in_data holds a valid sample.
- in_ready  output  1  block can accept a sample this cycle.
- in_data  input  DATA_W  sample value.
- out_valid  output  1  out_max and out_idx hold a valid result.
- out_ready  input  1  consumer takes the result this cycle.
- out_max  output  DATA_W  largest sample of the frame.
- out_idx  output  IDX_W  position of the largest sample within the frame, 0-based.

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, count 0, out_valid 0, out_max 0, out_idx 0.
- Accept: a sample is accepted when in_valid and in_ready are both 1 at a rising edge.
- in_ready: combinational, equal to (state != HOLD) and not clear.
- Release: a result is released when out_valid and out_ready are both 1 at a rising edge.
- States:
  - IDLE: no samples of the current frame have been accepted yet.
  - ACCUM: between 1 and FRAME_LEN-1 samples have been accepted.
  - HOLD: the result is presented on the outputs.
- IDLE, on accept:
  - Load max_reg with in_data, idx_reg with 0, count with 1.
  - Go to ACCUM.
- ACCUM, on accept:
  - If in_data > max_reg (strict, unsigned), load max_reg with in_data and idx_reg with count.
  - Increment count.
  - If this was sample number FRAME_LEN (count was FRAME_LEN-1), go to HOLD and set out_valid to 1 on the same edge.
- Ties: strict comparison, so the earliest occurrence of the maximum keeps its index.
- HOLD:
  - out_max and out_idx drive max_reg and idx_reg; they stay stable while out_valid=1 and must not change before release.
  - in_ready=0.
  - On release: out_valid goes to 0, count to 0, state to IDLE. The next sample can be accepted from the following cycle.
- Latency: out_valid rises on the same edge that accepts the last sample of the frame. Throughput is at best one frame per FRAME_LEN+1 cycles.
- Idle gaps: when in_valid is low, no state changes. Gaps inside a frame are allowed and of any length.
- out_ready held high: with out_valid=1 the result is released on the first edge, so out_valid is high for exactly one cycle.
- out_ready while out_valid=0: ignored.
- clear:
  - Has priority over every handshake in the same cycle.
  - Goes to IDLE, sets count to 0 and out_valid to 0.
  - A pending result or partial frame is discarded; a sample offered in the same cycle is not accepted.
  - out_max and out_idx keep their values but are meaningless while out_valid=0.
- Reset mid-frame or in HOLD: immediately returns to the reset values; the partial frame or pending result is lost.
- Index arithmetic: count and idx_reg are IDX_W wide and never exceed FRAME_LEN-1, so no wrap occurs.

Test Plan:
- Basic frame: FRAME_LEN=4, send 3, 9, 5, 1 back-to-back with out_ready=1 -> out_valid pulses once, one cycle, with out_max=9 and out_idx=1.
- Ties and extremes: send 7, 255, 255, 0 -> out_max=255, out_idx=1. Then send 0, 0, 0, 0 -> out_max=0, out_idx=0.
- Backpressure: frame 2, 4, 6, 8 with out_ready=0 for 5 cycles -> out_valid=1 and in_ready=0 for all 5 cycles, out_max=8 and out_idx=3 stable. Raise out_ready -> release; in_ready=1 the next cycle.
- Gapped input: send 10, gap of 3 cycles, 20, gap, 15, 30 -> out_max=30, out_idx=3; no state change during the gaps.
- clear: send 50, 60, assert clear with in_valid=1 and in_data=99, then send 1, 2, 3, 4 -> 99 is not accepted; result is out_max=4, out_idx=3.
- Async reset: drop rst_n while in HOLD with out_max=200 -> out_valid, out_max and out_idx read 0 before the next clk edge. After reset, a new frame 5, 1, 1, 1 -> out_max=5, out_idx=0.
